// File: rtl/mpt_pkg.sv
// rtl/mpt_pkg.sv - shared types for the MPT walker request arbiter
package mpt_pkg;

    localparam int MPT_SPA_MAX_W = 64;

    typedef enum logic [1:0] {
        MPT_ACCESS_NONE  = 2'd0,
        MPT_ACCESS_READ  = 2'd1,
        MPT_ACCESS_WRITE = 2'd2,
        MPT_ACCESS_EXEC  = 2'd3
    } mpt_access_e;

    typedef enum logic [2:0] {
        FORMAT_NO_FAULT     = 3'd0,
        FORMAT_RSVD_BITS    = 3'd1,
        FORMAT_INVALID_PERM = 3'd2,
        FORMAT_BAD_MODE     = 3'd3,
        FORMAT_LEAF_LEVEL   = 3'd4,
        FORMAT_RSVD_5       = 3'd5,
        FORMAT_RSVD_6       = 3'd6,
        FORMAT_RSVD_7       = 3'd7
    } page_format_fault_e;

    typedef struct packed {
        logic [MPT_SPA_MAX_W-1:0] spa;
        mpt_access_e              access_type;
    } mptw_arb_req_t;

    typedef struct packed {
        logic               fault;
        page_format_fault_e format;
    } mptw_arb_resp_t;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/mptw_tag_fifo.sv
// rtl/mptw_tag_fifo.sv - in-order FIFO of requester tags for outstanding walks
module mptw_tag_fifo
    import mpt_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [DATA_W-1:0]        push_data_i,
    input  logic                     pop_i,
    output logic [DATA_W-1:0]        pop_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;
    logic              w_push;
    logic              w_pop;

    assign full_o     = (r_count == (PTR_W+1)'(DEPTH));
    assign empty_o    = (r_count == '0);
    assign count_o    = r_count;
    assign pop_data_o = r_mem[r_rd_ptr];
    assign w_push     = push_i & ~full_o;
    assign w_pop      = pop_i & ~empty_o;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + {{PTR_W{1'b0}}, w_push} - {{PTR_W{1'b0}}, w_pop};
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push && !flush_i) r_mem[r_wr_ptr] <= push_data_i;
    end

endmodule

// File: rtl/mptw_req_arbiter.sv
// rtl/mptw_req_arbiter.sv - round-robin arbiter sharing one MPT walker port
module mptw_req_arbiter
    import mpt_pkg::*;
#(
    parameter int NUM_REQ         = 3,
    parameter int MAX_OUTSTANDING = 4,
    parameter int SPA_WIDTH       = 64
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               flush_i,
    input  logic [NUM_REQ-1:0]                 req_valid_i,
    output logic [NUM_REQ-1:0]                 req_ready_o,
    input  logic [NUM_REQ*SPA_WIDTH-1:0]       req_spa_i,
    input  logic [NUM_REQ*2-1:0]               req_access_i,
    output logic                               walk_valid_o,
    input  logic                               walk_ready_i,
    output logic [SPA_WIDTH-1:0]               walk_spa_o,
    output logic [1:0]                         walk_access_o,
    input  logic                               walk_resp_valid_i,
    input  logic                               walk_resp_fault_i,
    input  logic [2:0]                         walk_resp_format_i,
    output logic [NUM_REQ-1:0]                 resp_valid_o,
    output logic                               resp_fault_o,
    output logic [2:0]                         resp_format_o,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o,
    output logic                               orphan_err_o
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0]   r_rr;
    logic               r_lock;
    logic [IDX_W-1:0]   r_lock_idx;
    logic [NUM_REQ-1:0] r_resp_valid;
    mptw_arb_resp_t     r_resp;
    logic               r_orphan;

    logic               w_grant_found;
    logic [IDX_W-1:0]   w_grant_idx;
    logic               w_handshake;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic [IDX_W-1:0]   w_head;
    mptw_arb_req_t      w_sel_req;

    // A held lock wins outright; otherwise search upward from r_rr with wrap.
    always_comb begin
        int               c;
        logic [IDX_W-1:0] c_idx;
        c             = 0;
        c_idx         = '0;
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        if (r_lock) begin
            w_grant_found = 1'b1;
            w_grant_idx   = r_lock_idx;
        end else if (!w_full) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                c = int'(r_rr) + k;
                if (c >= NUM_REQ) c = c - NUM_REQ;
                c_idx = IDX_W'(c);
                if (!w_grant_found && req_valid_i[c_idx]) begin
                    w_grant_found = 1'b1;
                    w_grant_idx   = c_idx;
                end
            end
        end
    end

    always_comb begin
        w_sel_req.spa         = MPT_SPA_MAX_W'(req_spa_i[w_grant_idx*SPA_WIDTH +: SPA_WIDTH]);
        w_sel_req.access_type = mpt_access_e'(req_access_i[w_grant_idx*2 +: 2]);
    end

    assign walk_valid_o  = w_grant_found & ~flush_i & ~rst_i;
    assign walk_spa_o    = w_sel_req.spa[SPA_WIDTH-1:0];
    assign walk_access_o = w_sel_req.access_type;
    assign w_handshake   = walk_valid_o & walk_ready_i;
    assign w_pop         = walk_resp_valid_i & ~w_empty & ~flush_i;

    always_comb begin
        req_ready_o = '0;
        if (walk_valid_o) req_ready_o[w_grant_idx] = walk_ready_i;
    end

    mptw_tag_fifo #(
        .DEPTH  (MAX_OUTSTANDING),
        .DATA_W (IDX_W)
    ) u_tag_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .push_i      (w_handshake),
        .push_data_i (w_grant_idx),
        .pop_i       (w_pop),
        .pop_data_o  (w_head),
        .full_o      (w_full),
        .empty_o     (w_empty),
        .count_o     (outstanding_o)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rr         <= '0;
            r_lock       <= 1'b0;
            r_lock_idx   <= '0;
            r_resp_valid <= '0;
            r_resp       <= '{fault: 1'b0, format: FORMAT_NO_FAULT};
            r_orphan     <= 1'b0;
        end else if (flush_i) begin
            r_rr         <= '0;
            r_lock       <= 1'b0;
            r_resp_valid <= '0;
        end else begin
            if (walk_valid_o && !walk_ready_i) begin
                r_lock     <= 1'b1;
                r_lock_idx <= w_grant_idx;
            end
            if (w_handshake) begin
                r_lock <= 1'b0;
                r_rr   <= IDX_W'(rr_next(int'(w_grant_idx), NUM_REQ));
            end
            r_resp_valid <= '0;
            if (w_pop) begin
                r_resp_valid <= NUM_REQ'(1) << w_head;
                r_resp       <= '{fault: walk_resp_fault_i,
                                  format: page_format_fault_e'(walk_resp_format_i)};
            end
            if (walk_resp_valid_i && w_empty) r_orphan <= 1'b1;
        end
    end

    assign resp_valid_o  = r_resp_valid;
    assign resp_fault_o  = r_resp.fault;
    assign resp_format_o = r_resp.format;
    assign orphan_err_o  = r_orphan;

endmodule

// File: tb/tb_mptw_req_arbiter.sv
// tb/tb_mptw_req_arbiter.sv - directed scoreboard bench for mptw_req_arbiter
module tb_mptw_req_arbiter;

    localparam int NR = 3;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic            flush_i = 1'b0;
    logic [NR-1:0]   req_valid_i = '0;
    logic [NR-1:0]   req_ready_o;
    logic [NR*64-1:0] req_spa_i;
    logic [NR*2-1:0] req_access_i;
    logic            walk_valid_o;
    logic            walk_ready_i = 1'b0;
    logic [63:0]     walk_spa_o;
    logic [1:0]      walk_access_o;
    logic            walk_resp_valid_i = 1'b0;
    logic            walk_resp_fault_i = 1'b0;
    logic [2:0]      walk_resp_format_i = '0;
    logic [NR-1:0]   resp_valid_o;
    logic            resp_fault_o;
    logic [2:0]      resp_format_o;
    logic [2:0]      outstanding_o;
    logic            orphan_err_o;

    logic [63:0] spa_a [NR];

    typedef struct { int idx; logic [63:0] spa; } g_t;
    typedef struct { int idx; logic f; logic [2:0] fmt; } r_t;
    g_t g_q[$];
    r_t r_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    logic        prev_wait = 1'b0;
    logic [63:0] prev_spa  = '0;

    mptw_req_arbiter #(.NUM_REQ(NR), .MAX_OUTSTANDING(4), .SPA_WIDTH(64)) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .flush_i            (flush_i),
        .req_valid_i        (req_valid_i),
        .req_ready_o        (req_ready_o),
        .req_spa_i          (req_spa_i),
        .req_access_i       (req_access_i),
        .walk_valid_o       (walk_valid_o),
        .walk_ready_i       (walk_ready_i),
        .walk_spa_o         (walk_spa_o),
        .walk_access_o      (walk_access_o),
        .walk_resp_valid_i  (walk_resp_valid_i),
        .walk_resp_fault_i  (walk_resp_fault_i),
        .walk_resp_format_i (walk_resp_format_i),
        .resp_valid_o       (resp_valid_o),
        .resp_fault_o       (resp_fault_o),
        .resp_format_o      (resp_format_o),
        .outstanding_o      (outstanding_o),
        .orphan_err_o       (orphan_err_o)
    );

    always #5 clk_i = ~clk_i;

    always_comb begin
        req_spa_i    = '0;
        req_access_i = '0;
        for (int i = 0; i < NR; i++) begin
            req_spa_i[i*64 +: 64] = spa_a[i];
            req_access_i[i*2 +: 2] = 2'(i + 1);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic exp_g(input int idx);
        g_q.push_back('{idx, spa_a[idx]});
    endtask

    task automatic exp_r(input int idx, input logic f, input logic [2:0] fmt);
        r_q.push_back('{idx, f, fmt});
    endtask

    task automatic respond(input logic f, input logic [2:0] fmt);
        walk_resp_valid_i  = 1'b1;
        walk_resp_fault_i  = f;
        walk_resp_format_i = fmt;
        tick();
        walk_resp_valid_i  = 1'b0;
    endtask

    // Handshake and response monitor, sampled away from the active edge.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (prev_wait && !flush_i) begin
                chk("lock_valid_held", 64'(walk_valid_o), 64'd1);
                chk("lock_spa_held", walk_spa_o, prev_spa);
            end
            if (walk_valid_o && walk_ready_i) begin
                if (g_q.size() == 0) begin
                    chk("grant_unexpected", 64'd1, 64'd0);
                end else begin
                    g_t e;
                    e = g_q.pop_front();
                    chk("grant_idx", 64'(req_ready_o), 64'(1) << e.idx);
                    chk("grant_spa", walk_spa_o, e.spa);
                    chk("grant_access", 64'(walk_access_o), 64'(e.idx + 1));
                end
            end
            if (|resp_valid_o) begin
                if (r_q.size() == 0) begin
                    chk("resp_unexpected", 64'(resp_valid_o), 64'd0);
                end else begin
                    r_t r;
                    r = r_q.pop_front();
                    chk("resp_onehot", 64'(resp_valid_o), 64'(1) << r.idx);
                    chk("resp_fault", 64'(resp_fault_o), 64'(r.f));
                    chk("resp_format", 64'(resp_format_o), 64'(r.fmt));
                end
            end
        end
        prev_wait = walk_valid_o & ~walk_ready_i & ~flush_i & ~rst_i;
        prev_spa  = walk_spa_o;
    end

    initial begin
        spa_a[0] = 64'h0000_0000_1000_0000;
        spa_a[1] = 64'h0000_0000_2000_0000;
        spa_a[2] = 64'h0000_0000_3000_0000;
        // Reset with traffic pending: nothing may be presented.
        req_valid_i  = 3'b111;
        walk_ready_i = 1'b1;
        tick();
        tick();
        chk("rst_walk_valid", 64'(walk_valid_o), 64'd0);
        chk("rst_req_ready", 64'(req_ready_o), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid_o), 64'd0);
        chk("rst_resp_fault", 64'(resp_fault_o), 64'd0);
        chk("rst_resp_format", 64'(resp_format_o), 64'd0);
        chk("rst_outstanding", 64'(outstanding_o), 64'd0);
        chk("rst_orphan", 64'(orphan_err_o), 64'd0);

        // Round robin 0,1,2 then back to 0.
        exp_g(0); exp_g(1); exp_g(2);
        rst_i = 1'b0;
        tick(); tick(); tick();
        req_valid_i = '0;
        chk("rr_outstanding3", 64'(outstanding_o), 64'd3);
        exp_r(0, 1'b0, 3'd0); respond(1'b0, 3'd0);
        exp_r(1, 1'b1, 3'd3); respond(1'b1, 3'd3);
        exp_r(2, 1'b0, 3'd5); respond(1'b0, 3'd5);
        req_valid_i = 3'b111;
        exp_g(0);
        tick();
        req_valid_i = '0;
        exp_r(0, 1'b0, 3'd0); respond(1'b0, 3'd0);
        chk("rr_drained", 64'(outstanding_o), 64'd0);

        // Lock on requester 2 while the walker stalls.
        spa_a[2]     = 64'h0000_0000_8000_1000;
        req_valid_i  = 3'b100;
        walk_ready_i = 1'b0;
        tick(); tick();
        req_valid_i = 3'b101;
        #1;
        chk("lock_spa", walk_spa_o, 64'h8000_1000);
        chk("lock_no_ready", 64'(req_ready_o), 64'd0);
        tick(); tick();
        chk("lock_still_2", walk_spa_o, 64'h8000_1000);
        exp_g(2); exp_g(0);
        walk_ready_i = 1'b1;
        tick();
        req_valid_i = 3'b001;
        #1;
        chk("lock_next_0", walk_spa_o, spa_a[0]);
        tick();
        req_valid_i = '0;
        exp_r(2, 1'b0, 3'd1); respond(1'b0, 3'd1);
        exp_r(0, 1'b0, 3'd0); respond(1'b0, 3'd0);

        // Fill to MAX_OUTSTANDING; a pop in the same cycle must not grant.
        req_valid_i = 3'b111;
        exp_g(1); exp_g(2); exp_g(0); exp_g(1);
        tick(); tick(); tick(); tick();
        req_valid_i = 3'b010;
        #1;
        chk("full_no_valid", 64'(walk_valid_o), 64'd0);
        chk("full_no_ready", 64'(req_ready_o), 64'd0);
        chk("full_count", 64'(outstanding_o), 64'd4);
        tick();
        walk_resp_valid_i  = 1'b1;
        walk_resp_fault_i  = 1'b0;
        walk_resp_format_i = 3'd4;
        exp_r(1, 1'b0, 3'd4);
        #1;
        chk("full_pop_no_grant", 64'(walk_valid_o), 64'd0);
        tick();
        walk_resp_valid_i = 1'b0;
        #1;
        chk("after_pop_valid", 64'(walk_valid_o), 64'd1);
        chk("after_pop_ready", 64'(req_ready_o), 64'b010);
        chk("after_pop_count", 64'(outstanding_o), 64'd3);
        exp_g(1);
        tick();
        req_valid_i = '0;
        chk("refill_count", 64'(outstanding_o), 64'd4);
        exp_r(2, 1'b0, 3'd0); respond(1'b0, 3'd0);
        exp_r(0, 1'b0, 3'd0); respond(1'b0, 3'd0);
        exp_r(1, 1'b0, 3'd0); respond(1'b0, 3'd0);
        exp_r(1, 1'b0, 3'd0); respond(1'b0, 3'd0);

        // Issue 1 then 0; responses route back in order with 1-cycle latency.
        req_valid_i = 3'b010; exp_g(1); tick();
        req_valid_i = 3'b001; exp_g(0); tick();
        req_valid_i = '0;
        exp_r(1, 1'b1, 3'd2); respond(1'b1, 3'd2);
        chk("r1_valid", 64'(resp_valid_o), 64'b010);
        chk("r1_fault", 64'(resp_fault_o), 64'd1);
        chk("r1_format", 64'(resp_format_o), 64'd2);
        tick();
        chk("r1_idle_valid", 64'(resp_valid_o), 64'd0);
        chk("r1_hold_fault", 64'(resp_fault_o), 64'd1);
        chk("r1_hold_format", 64'(resp_format_o), 64'd2);
        exp_r(0, 1'b0, 3'd0); respond(1'b0, 3'd0);
        chk("r2_valid", 64'(resp_valid_o), 64'b001);
        chk("r2_fault", 64'(resp_fault_o), 64'd0);

        // Orphan response with an empty FIFO.
        chk("pre_orphan", 64'(orphan_err_o), 64'd0);
        respond(1'b1, 3'd7);
        chk("orphan_no_resp", 64'(resp_valid_o), 64'd0);
        chk("orphan_set", 64'(orphan_err_o), 64'd1);
        chk("orphan_fault_kept", 64'(resp_fault_o), 64'd0);
        tick(); tick();
        chk("orphan_sticky", 64'(orphan_err_o), 64'd1);

        // Asynchronous reset mid-operation with a lock pending.
        req_valid_i  = 3'b001;
        walk_ready_i = 1'b1;
        exp_g(0);
        tick();
        req_valid_i  = 3'b100;
        walk_ready_i = 1'b0;
        tick();
        rst_i = 1'b1;
        #1;
        chk("arst_valid", 64'(walk_valid_o), 64'd0);
        chk("arst_count", 64'(outstanding_o), 64'd0);
        chk("arst_orphan", 64'(orphan_err_o), 64'd0);
        tick();
        rst_i       = 1'b0;
        req_valid_i = '0;

        // Flush with two outstanding and a lock held; in-flush response dropped.
        req_valid_i  = 3'b011;
        walk_ready_i = 1'b1;
        exp_g(0); exp_g(1);
        tick(); tick();
        req_valid_i  = 3'b100;
        walk_ready_i = 1'b0;
        tick();
        chk("pre_flush_count", 64'(outstanding_o), 64'd2);
        flush_i           = 1'b1;
        walk_resp_valid_i = 1'b1;
        #1;
        chk("flush_no_valid", 64'(walk_valid_o), 64'd0);
        tick();
        flush_i           = 1'b0;
        walk_resp_valid_i = 1'b0;
        req_valid_i       = 3'b010;
        walk_ready_i      = 1'b1;
        #1;
        chk("flush_count", 64'(outstanding_o), 64'd0);
        chk("flush_orphan", 64'(orphan_err_o), 64'd0);
        chk("flush_resp", 64'(resp_valid_o), 64'd0);
        chk("flush_unlock", walk_spa_o, spa_a[1]);
        exp_g(1);
        tick();
        req_valid_i = '0;
        exp_r(1, 1'b0, 3'd0); respond(1'b0, 3'd0);
        respond(1'b0, 3'd0);
        chk("post_flush_orphan", 64'(orphan_err_o), 64'd1);

        tick();
        chk("grant_q_empty", 64'(g_q.size()), 64'd0);
        chk("resp_q_empty", 64'(r_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
